send_data: RTL and testbench

SEND_DATA -- requirements
Module: send_data

---
 rtl/usb_tx_pkg.sv | 26 ++
 rtl/crc16_serial.sv | 30 +++
 rtl/send_data.sv | 151 +++++++++++++++
 tb/tb_send_data.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB transmit path: FSM states, field lengths
// and CRC16 constants used by both the transmitter and the receiver.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    PID,
    DATA,
    CRC,
    EOP
  } tx_state_t;

  localparam int SYNC_BITS  = 8;
  localparam int PID_BITS   = 8;
  localparam int DATA_BITS  = 64;
  localparam int CRC_BITS   = 16;
  localparam int EOP_CYCLES = 3;

  // Wide enough to count the longest field (DATA_BITS - 1)
  localparam int CNT_W = 7;

  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

endpackage

// File: rtl/crc16_serial.sv
// Bit-serial CRC16 (poly 0x8005), MSB-side feedback. Shared between the
// transmitter and the receiver.
module crc16_serial
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] r_crc;
  logic        w_fb;

  assign w_fb = r_crc[15] ^ bit_in;
  assign crc  = r_crc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crc <= CRC16_INIT;
    end else if (init) begin
      r_crc <= CRC16_INIT;
    end else if (en) begin
      r_crc <= {r_crc[14:0], 1'b0} ^ (w_fb ? CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/send_data.sv
// USB packet serializer: emits SYNC, PID, 64-bit payload and CRC16 as an NRZ
// bit stream, then drives EOP. Stalls on the stuffer's pause in DATA/CRC.
module send_data
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        t_data_start,
  input  logic [3:0]  pid,
  input  logic [63:0] data,
  input  logic        pause,
  output logic        bit_out,
  output logic        bit_valid,
  output logic        en_stuff_L,
  output logic        se0,
  output logic        busy,
  output logic        finish
);

  tx_state_t        r_state;
  tx_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       r_pid;
  logic [63:0]      r_data;
  logic [15:0]      w_crc;
  logic             w_accept;
  logic             w_stuff;
  logic             w_hold;
  logic             w_crc_en;

  function automatic logic is_last(input logic [CNT_W-1:0] cnt, input int len);
    return cnt == CNT_W'(len - 1);
  endfunction

  assign w_accept = (r_state == IDLE) && t_data_start;
  assign w_stuff  = (r_state == DATA) || (r_state == CRC);
  assign w_hold   = w_stuff && pause;
  assign w_crc_en = (r_state == DATA) && !pause;

  crc16_serial u_crc (
    .clk    (clk),
    .rst    (rst),
    .init   (w_accept),
    .en     (w_crc_en),
    .bit_in (r_data[r_cnt[5:0]]),
    .crc    (w_crc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (t_data_start) w_state_nxt = SYNC;
      end
      SYNC: begin
        if (is_last(r_cnt, SYNC_BITS)) begin
          w_state_nxt = PID;
          w_cnt_nxt   = '0;
        end
      end
      PID: begin
        if (is_last(r_cnt, PID_BITS)) begin
          w_state_nxt = DATA;
          w_cnt_nxt   = '0;
        end
      end
      DATA: begin
        if (w_hold) begin
          w_cnt_nxt = r_cnt;
        end else if (is_last(r_cnt, DATA_BITS)) begin
          w_state_nxt = CRC;
          w_cnt_nxt   = '0;
        end
      end
      CRC: begin
        if (w_hold) begin
          w_cnt_nxt = r_cnt;
        end else if (is_last(r_cnt, CRC_BITS)) begin
          w_state_nxt = EOP;
          w_cnt_nxt   = '0;
        end
      end
      EOP: begin
        if (is_last(r_cnt, EOP_CYCLES)) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Captured pid/data are only written on start accept, so they stay stable mid-packet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pid   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_pid  <= pid;
        r_data <= data;
      end
    end
  end

  always_comb begin
    bit_out    = 1'b0;
    bit_valid  = 1'b0;
    en_stuff_L = 1'b1;
    se0        = 1'b0;
    finish     = 1'b0;
    busy       = (r_state != IDLE);
    case (r_state)
      SYNC: begin
        bit_out   = is_last(r_cnt, SYNC_BITS);
        bit_valid = 1'b1;
      end
      PID: begin
        bit_out   = r_cnt[2] ? ~r_pid[r_cnt[1:0]] : r_pid[r_cnt[1:0]];
        bit_valid = 1'b1;
      end
      DATA: begin
        bit_out    = r_data[r_cnt[5:0]];
        bit_valid  = !pause;
        en_stuff_L = 1'b0;
      end
      CRC: begin
        // ~cnt selects bit 15-cnt: complemented CRC, MSB first
        bit_out    = ~w_crc[~r_cnt[3:0]];
        bit_valid  = !pause;
        en_stuff_L = 1'b0;
      end
      EOP: begin
        se0    = !is_last(r_cnt, EOP_CYCLES);
        finish = is_last(r_cnt, EOP_CYCLES);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_send_data.sv
// Directed self-checking bench for send_data: expected bit streams, CRC and
// timing come from a small reference model of the packet format.
`timescale 1ns/1ps
module tb_send_data;

  logic        clk;
  logic        rst;
  logic        t_data_start;
  logic [3:0]  pid;
  logic [63:0] data;
  logic        pause;
  logic        bit_out;
  logic        bit_valid;
  logic        en_stuff_L;
  logic        se0;
  logic        busy;
  logic        finish;

  int checks = 0;
  int errors = 0;

  logic [5:0] w_obs;
  assign w_obs = {busy, bit_valid, bit_out, en_stuff_L, se0, finish};

  localparam logic [5:0] IDLE_OUTS = 6'b000100;

  send_data dut (
    .clk          (clk),
    .rst          (rst),
    .t_data_start (t_data_start),
    .pid          (pid),
    .data         (data),
    .pause        (pause),
    .bit_out      (bit_out),
    .bit_valid    (bit_valid),
    .en_stuff_L   (en_stuff_L),
    .se0          (se0),
    .busy         (busy),
    .finish       (finish)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Sends one packet and checks every cycle against the model.
  // pa/pb: bit indices at which pause is held for one cycle (-1 = none).
  // psp: hold pause through SYNC and PID. hold: keep start high and
  // scramble pid/data inputs mid-packet. abort_at: bit index to assert rst.
  task automatic run_pkt(input string tag, input logic [3:0] p, input logic [63:0] d,
                         input int pa, input int pb, input bit psp, input bit hold,
                         input int abort_at, input int exp_fin);
    logic        exp_bits [96];
    logic [15:0] c;
    logic [15:0] res;
    logic [5:0]  expv;
    logic [5:0]  obs;
    int          idx;
    int          eop;
    int          fin_cyc;
    bit          ua, ub, pz, stuff, done;

    c = 16'hFFFF;
    for (int i = 0; i < 8; i++) exp_bits[i] = (i == 7);
    for (int i = 0; i < 4; i++) begin
      exp_bits[8 + i]  = p[i];
      exp_bits[12 + i] = ~p[i];
    end
    for (int i = 0; i < 64; i++) begin
      exp_bits[16 + i] = d[i];
      c = crc_step(c, d[i]);
    end
    for (int i = 0; i < 16; i++) exp_bits[80 + i] = ~c[15 - i];

    idx = 0; eop = 0; fin_cyc = 0; res = 16'hFFFF;
    ua = 0; ub = 0; done = 0;

    @(negedge clk);
    pid = p; data = d; t_data_start = 1'b1; pause = 1'b0;
    #1 chk({tag, "_idle_before_start"}, w_obs, IDLE_OUTS);

    for (int cyc = 1; cyc <= 110 && !done; cyc++) begin
      @(negedge clk);
      if (!hold && cyc == 1) t_data_start = 1'b0;
      if (!hold && cyc == 50) t_data_start = 1'b1;
      if (!hold && cyc == 51) t_data_start = 1'b0;
      if (hold && cyc == 1) begin
        pid = ~p; data = ~d;
      end
      pz = psp && (idx < 16);
      if (idx == pa && !ua) begin pz = 1; ua = 1; end
      if (idx == pb && !ub) begin pz = 1; ub = 1; end
      pause = pz;

      if (abort_at >= 0 && idx == abort_at) begin
        rst = 1'b1;
        #1 chk({tag, "_rst_immediate"}, w_obs, IDLE_OUTS);
        t_data_start = 1'b0; pause = 1'b0;
        repeat (4) begin
          @(negedge clk);
          #1 chk({tag, "_rst_held_no_finish"}, w_obs, IDLE_OUTS);
        end
        @(negedge clk);
        rst = 1'b0;
        #1 chk({tag, "_after_rst_idle"}, w_obs, IDLE_OUTS);
        done = 1;
      end else begin
        #1;
        if (idx < 96) begin
          stuff = (idx >= 16);
          expv  = {1'b1, !(pz && stuff), exp_bits[idx], !stuff, 1'b0, 1'b0};
          obs   = w_obs;
        end else begin
          expv = {1'b1, 1'b0, 1'b0, 1'b1, (eop < 2), (eop == 2)};
          obs  = w_obs & 6'b110111;
        end
        chk($sformatf("%s_cyc%0d", tag, cyc), obs, expv);

        if (idx < 96) begin
          if (idx >= 16 && bit_valid) res = crc_step(res, bit_out);
          if (!(pz && stuff)) idx++;
        end else begin
          if (eop == 2) begin
            fin_cyc = cyc;
            done = 1;
          end
          eop++;
        end
      end
    end

    if (abort_at < 0) begin
      pause = 1'b0;
      chk({tag, "_finish_cycle"}, fin_cyc, exp_fin);
      chk({tag, "_crc_residue"}, res, 16'h800D);
    end
  endtask

  initial begin
    rst = 1'b1; t_data_start = 1'b0; pause = 1'b0; pid = 4'h0; data = 64'h0;
    #3 chk("reset_outputs", w_obs, IDLE_OUTS);
    t_data_start = 1'b1; pause = 1'b1;
    #4 chk("reset_ignores_inputs", w_obs, IDLE_OUTS);
    t_data_start = 1'b0; pause = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("post_reset_idle", w_obs, IDLE_OUTS);

    // Basic packet, all-zero payload
    run_pkt("case1", 4'h3, 64'h0, -1, -1, 0, 0, -1, 99);
    // Arbitrary payload
    run_pkt("case2", 4'hB, 64'hDEAD_BEEF_0123_CAFE, -1, -1, 0, 0, -1, 99);
    // One-cycle pauses at DATA bit 5 and on the last CRC bit
    run_pkt("case3", 4'h6, 64'hA5A5_0F0F_FFFF_0001, 21, 95, 0, 0, -1, 101);
    // Pause during SYNC/PID has no effect
    run_pkt("case4", 4'h3, 64'h0, -1, -1, 1, 0, -1, 99);
    // Start held high: back-to-back packets, capture stable mid-packet
    run_pkt("case5a", 4'h5, 64'h1234_5678_9ABC_DEF0, -1, -1, 0, 1, -1, 99);
    run_pkt("case5b", 4'hA, ~64'h1234_5678_9ABC_DEF0, -1, -1, 0, 1, -1, 99);
    t_data_start = 1'b0;
    // Reset at DATA bit 30, then a clean packet
    run_pkt("case6_abort", 4'hC, 64'hFEDC_BA98_7654_3210, -1, -1, 0, 0, 46, 0);
    run_pkt("case6_after", 4'h9, 64'h0F1E_2D3C_4B5A_6978, -1, -1, 0, 0, -1, 99);

    @(negedge clk);
    #1 chk("final_idle", w_obs, IDLE_OUTS);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
